hazard_ctrl_unit: RTL and testbench

//  Parametrised hazard controller for the 5-stage pipeline: EX-stage and decode-stage (branch compare) forwarding,

---
 rtl/hazard_pkg.sv | 11 +
 rtl/hazard_md_timer.sv | 58 +++++
 rtl/hazard_ctrl_unit.sv | 118 +++++++++++
 tb/tb_hazard_ctrl_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: forwarding selects and MD FSM state encoding.
package hazard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_MD_BUSY = 1'b1;

endpackage

// File: rtl/hazard_md_timer.sv
// Mul/div occupancy FSM: counts the EX cycles after the start cycle and pulses done in the last one.
module hazard_md_timer
   import hazard_pkg::*;
#(
   parameter int unsigned MD_LATENCY = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic md_start,
   output logic busy,
   output logic done_c
);

   localparam int unsigned CW = $clog2(MD_LATENCY + 1);

   logic [0:0]    state_q, state_nx;
   logic [CW-1:0] cnt_q, cnt_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_nx;
         cnt_q   <= cnt_nx;
      end
   end

   // Single-cycle ops never leave IDLE; done is raised in the start cycle instead.
   always_comb begin
      state_nx = state_q;
      cnt_nx   = cnt_q;
      done_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (md_start) begin
               if (MD_LATENCY > 1) begin
                  state_nx = ST_MD_BUSY;
                  cnt_nx   = CW'(MD_LATENCY - 1);
               end else begin
                  done_c = 1'b1;
               end
            end
         end
         ST_MD_BUSY: begin
            cnt_nx = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               done_c   = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign busy = (state_q == ST_MD_BUSY);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage pipeline: forwarding, load-use/branch stalls, mul/div freeze.
// Optional stall statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned MD_LATENCY = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] rs_d,
   input  logic [REG_AW-1:0] rt_d,
   input  logic [REG_AW-1:0] rs_e,
   input  logic [REG_AW-1:0] rt_e,
   input  logic [REG_AW-1:0] wr_reg_e,
   input  logic [REG_AW-1:0] wr_reg_m,
   input  logic [REG_AW-1:0] wr_reg_w,
   input  logic              reg_write_e,
   input  logic              reg_write_m,
   input  logic              reg_write_w,
   input  logic              mem_to_reg_e,
   input  logic              mem_to_reg_m,
   input  logic              branch_d,
   input  logic              md_start_e,
   output logic [1:0]        fwd_ae,
   output logic [1:0]        fwd_be,
   output logic              fwd_ad,
   output logic              fwd_bd,
   output logic              stall_f,
   output logic              stall_d,
   output logic              flush_e,
   output logic              hold_e,
   output logic              md_busy,
   output logic              md_done,
   output logic [CNT_W-1:0]  stall_cyc,
   output logic [CNT_W-1:0]  lw_events
);

   // Register 0 is hard-wired zero, so a write to it never produces a hazard.
   function automatic logic hit(input logic en, input logic [REG_AW-1:0] wr,
                                input logic [REG_AW-1:0] src);
      return en && (wr != '0) && (wr == src);
   endfunction

   logic busy, done_c, lw_stall, br_stall, haz_stall;

   hazard_md_timer #(.MD_LATENCY(MD_LATENCY)) u_md_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .md_start (md_start_e),
      .busy     (busy),
      .done_c   (done_c)
   );

   assign lw_stall  = hit(mem_to_reg_e, wr_reg_e, rs_d) || hit(mem_to_reg_e, wr_reg_e, rt_d);
   assign br_stall  = branch_d &&
                      (hit(reg_write_e, wr_reg_e, rs_d) || hit(reg_write_e, wr_reg_e, rt_d) ||
                       hit(mem_to_reg_m, wr_reg_m, rs_d) || hit(mem_to_reg_m, wr_reg_m, rt_d));
   assign haz_stall = lw_stall || br_stall;

   // Outputs are forced low while reset is held; a busy mul/div hold overrides the bubble.
   always_comb begin
      fwd_ae  = FWD_RF;
      fwd_be  = FWD_RF;
      fwd_ad  = 1'b0;
      fwd_bd  = 1'b0;
      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_e = 1'b0;
      hold_e  = 1'b0;
      md_busy = 1'b0;
      md_done = 1'b0;
      if (rst_n) begin
         if (hit(reg_write_m, wr_reg_m, rs_e))      fwd_ae = FWD_MEM;
         else if (hit(reg_write_w, wr_reg_w, rs_e)) fwd_ae = FWD_WB;
         if (hit(reg_write_m, wr_reg_m, rt_e))      fwd_be = FWD_MEM;
         else if (hit(reg_write_w, wr_reg_w, rt_e)) fwd_be = FWD_WB;
         fwd_ad  = hit(reg_write_m, wr_reg_m, rs_d);
         fwd_bd  = hit(reg_write_m, wr_reg_m, rt_d);
         md_busy = busy;
         md_done = done_c;
         if (busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            hold_e  = 1'b1;
         end else begin
            stall_f = haz_stall;
            stall_d = haz_stall;
            flush_e = haz_stall;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stall_cyc_q, lw_events_q;

   // Saturating counters; only reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cyc_q <= '0;
         lw_events_q <= '0;
      end else begin
         if (stall_d && (stall_cyc_q != '1))
            stall_cyc_q <= stall_cyc_q + CNT_W'(1);
         if (lw_stall && !busy && (lw_events_q != '1))
            lw_events_q <= lw_events_q + CNT_W'(1);
      end
   end

   assign stall_cyc = stall_cyc_q;
   assign lw_events = lw_events_q;
`else
   assign stall_cyc = '0;
   assign lw_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed scoreboard bench for hazard_ctrl_unit (MD_LATENCY 4 and 1 instances driven in parallel).
module tb_hazard_ctrl_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_reg_e, wr_reg_m, wr_reg_w;
   logic       reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m;
   logic       branch_d, md_start_e;

   logic [1:0]  fwd_ae, fwd_be, fwd_ae1, fwd_be1;
   logic        fwd_ad, fwd_bd, stall_f, stall_d, flush_e, hold_e, md_busy, md_done;
   logic        fwd_ad1, fwd_bd1, stall_f1, stall_d1, flush_e1, hold_e1, md_busy1, md_done1;
   logic [15:0] stall_cyc, lw_events, stall_cyc1, lw_events1;

   typedef struct {
      string       tag;
      logic [11:0] v;
      logic [1:0]  v1;
      bit          lw;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_sc = '0;
   logic [15:0] exp_lw = '0;

   always #5 clk = ~clk;

   hazard_ctrl_unit #(.REG_AW(5), .MD_LATENCY(4), .CNT_W(16)) dut4 (
      .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
      .wr_reg_e(wr_reg_e), .wr_reg_m(wr_reg_m), .wr_reg_w(wr_reg_w),
      .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
      .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m), .branch_d(branch_d),
      .md_start_e(md_start_e), .fwd_ae(fwd_ae), .fwd_be(fwd_be), .fwd_ad(fwd_ad),
      .fwd_bd(fwd_bd), .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
      .hold_e(hold_e), .md_busy(md_busy), .md_done(md_done),
      .stall_cyc(stall_cyc), .lw_events(lw_events)
   );

   hazard_ctrl_unit #(.REG_AW(5), .MD_LATENCY(1), .CNT_W(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
      .wr_reg_e(wr_reg_e), .wr_reg_m(wr_reg_m), .wr_reg_w(wr_reg_w),
      .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
      .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m), .branch_d(branch_d),
      .md_start_e(md_start_e), .fwd_ae(fwd_ae1), .fwd_be(fwd_be1), .fwd_ad(fwd_ad1),
      .fwd_bd(fwd_bd1), .stall_f(stall_f1), .stall_d(stall_d1), .flush_e(flush_e1),
      .hold_e(hold_e1), .md_busy(md_busy1), .md_done(md_done1),
      .stall_cyc(stall_cyc1), .lw_events(lw_events1)
   );

   task automatic clear_inputs();
      rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
      wr_reg_e = '0; wr_reg_m = '0; wr_reg_w = '0;
      reg_write_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
      mem_to_reg_e = 1'b0; mem_to_reg_m = 1'b0; branch_d = 1'b0; md_start_e = 1'b0;
   endtask

   // Pops the oldest expectation and compares it with the current DUT outputs.
   task automatic check();
      exp_t        e;
      logic [11:0] obs;
      logic [15:0] want_sc, want_lw;
      e   = sb.pop_front();
      obs = {fwd_ae, fwd_be, fwd_ad, fwd_bd, stall_f, stall_d, flush_e, hold_e, md_busy, md_done};
`ifdef HAZARD_STATS_EN
      want_sc = exp_sc;
      want_lw = exp_lw;
`else
      want_sc = '0;
      want_lw = '0;
`endif
      checks++;
      assert (obs === e.v) else begin
         errors++;
         $error("FAIL %s outputs observed=%b expected=%b", e.tag, obs, e.v);
      end
      checks++;
      assert ({md_busy1, md_done1} === e.v1) else begin
         errors++;
         $error("FAIL %s lat1_md observed=%b expected=%b", e.tag, {md_busy1, md_done1}, e.v1);
      end
      checks++;
      assert ((stall_cyc === want_sc) && (lw_events === want_lw)) else begin
         errors++;
         $error("FAIL %s stats observed=%0d/%0d expected=%0d/%0d", e.tag,
                stall_cyc, lw_events, want_sc, want_lw);
      end
      if (e.v[4]) exp_sc++;
      if (e.lw)   exp_lw++;
   endtask

   task automatic step(input string tag, input logic [11:0] v, input logic [1:0] v1, input bit lw);
      sb.push_back('{tag, v, v1, lw});
      @(negedge clk);
      check();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clear_inputs();
      #1 rst_n = 1'b0;
      reg_write_m = 1'b1; wr_reg_m = 5'd8; rs_e = 5'd8;
      #1;
      sb.push_back('{"reset_outputs", 12'h000, 2'b00, 1'b0});
      check();
      clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Forwarding priority and zero-register suppression
      reg_write_m = 1'b1; wr_reg_m = 5'd8; rs_e = 5'd8; reg_write_w = 1'b1; wr_reg_w = 5'd8;
      step("fwd_mem_beats_wb", 12'h800, 2'b00, 1'b0);
      reg_write_m = 1'b0;
      step("fwd_wb", 12'h400, 2'b00, 1'b0);
      reg_write_m = 1'b1; rt_e = 5'd8; rs_d = 5'd8; rt_d = 5'd8;
      step("fwd_all_mem", 12'hAC0, 2'b00, 1'b0);
      clear_inputs();
      reg_write_m = 1'b1; reg_write_w = 1'b1;
      step("fwd_zero_reg", 12'h000, 2'b00, 1'b0);

      // Load-use stall for exactly one cycle
      clear_inputs();
      mem_to_reg_e = 1'b1; wr_reg_e = 5'd9; rt_d = 5'd9;
      step("lw_stall", 12'h038, 2'b00, 1'b1);
      clear_inputs();
      step("lw_released", 12'h000, 2'b00, 1'b0);

      // Branch-in-decode stalls
      branch_d = 1'b1; reg_write_e = 1'b1; wr_reg_e = 5'd4; rs_d = 5'd4;
      step("br_stall_e", 12'h038, 2'b00, 1'b0);
      clear_inputs();
      branch_d = 1'b1; mem_to_reg_m = 1'b1; wr_reg_m = 5'd4; rs_d = 5'd4;
      step("br_stall_m_load", 12'h038, 2'b00, 1'b0);
      branch_d = 1'b0;
      step("no_branch_no_stall", 12'h000, 2'b00, 1'b0);

      // Mul/div start coinciding with a load-use hazard, then busy period
      clear_inputs();
      mem_to_reg_e = 1'b1; wr_reg_e = 5'd9; rt_d = 5'd9; md_start_e = 1'b1;
      step("md_start_with_lw", 12'h038, 2'b01, 1'b1);
      md_start_e = 1'b0;
      step("md_busy1", 12'h036, 2'b00, 1'b0);
      step("md_busy2", 12'h036, 2'b00, 1'b0);
      step("md_busy3_done", 12'h037, 2'b00, 1'b0);
      step("md_back_idle_lw", 12'h038, 2'b00, 1'b1);
      clear_inputs();
      step("md_idle_quiet", 12'h000, 2'b00, 1'b0);

      // Reset during the second busy cycle aborts the op
      md_start_e = 1'b1;
      step("md2_start", 12'h000, 2'b01, 1'b0);
      md_start_e = 1'b0;
      step("md2_busy1", 12'h036, 2'b00, 1'b0);
      reg_write_m = 1'b1; wr_reg_m = 5'd8; rs_e = 5'd8;
      #2 rst_n = 1'b0;
      #1;
      exp_sc = '0;
      exp_lw = '0;
      sb.push_back('{"async_reset_mid_busy", 12'h000, 2'b00, 1'b0});
      check();
      clear_inputs();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step("post_rst_idle1", 12'h000, 2'b00, 1'b0);
      step("post_rst_idle2", 12'h000, 2'b00, 1'b0);
      step("post_rst_idle3", 12'h000, 2'b00, 1'b0);
      reg_write_m = 1'b1; wr_reg_m = 5'd8; rs_e = 5'd8;
      step("post_rst_fwd", 12'h800, 2'b00, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
